// File: rtl/mipi_csi_tx_packetizer.sv
// MIPI CSI-2 transmit packetizer, 4 lanes in the byte-clock domain.
// Turns frame/line commands and payload words into SYNC, header+ECC,
// payload and CRC-16 footer beats, with an LP gap between packets.
module mipi_csi_tx_packetizer #(
  parameter logic [1:0]  VC             = 2'd0,
  parameter logic [5:0]  DATA_TYPE      = 6'h2B,
  parameter int          GAP_CYCLES     = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hB8,
  parameter logic [15:0] FRAME_NUM_INIT = 16'd1
) (
  input  logic        clk_i,
  input  logic        reset_in,
  input  logic        frame_start_i,
  input  logic        line_start_i,
  input  logic        frame_end_i,
  input  logic [15:0] word_count_i,
  output logic        cmd_ready_o,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [31:0] lane_data_o,
  output logic        lane_valid_o,
  output logic        underrun_o,
  output logic [15:0] frame_num_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HEADER, S_PAYLOAD, S_FOOTER, S_GAP
  } state_t;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  // Each parity bit is the XOR of the header bits selected by its row mask.
  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return {2'b00, p};
  endfunction

  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    return c;
  endfunction

  // Lane 0 byte goes through the CRC first.
  function automatic logic [15:0] crc_word(input logic [15:0] crc, input logic [31:0] w);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) c = crc_byte(c, w[8*i +: 8]);
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    dt_q;
  logic [15:0]   wc_q;
  logic          long_q, is_fe_q;
  logic [13:0]   cnt_q, cnt_d;
  logic [7:0]    gap_q, gap_d;
  logic [15:0]   crc_q, crc_d;
  logic          accept;
  logic [31:0]   word_in, header, lane_d;
  logic          valid_d, ready_d;

  // A starved ready cycle still consumes a beat, as zeros.
  assign word_in = data_valid_i ? data_i : 32'h0;
  assign header  = {ecc_calc({wc_q, VC, dt_q}), wc_q, VC, dt_q};

  // Next-state and next-beat selection; lane outputs are registered from these.
  always_comb begin
    state_d = state_q;
    lane_d  = 32'h0;
    valid_d = 1'b0;
    ready_d = 1'b0;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    crc_d   = crc_q;
    accept  = 1'b0;
    if (data_ready_o) begin
      crc_d = crc_word(crc_q, word_in);
      cnt_d = cnt_q - 14'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (cmd_ready_o && (frame_start_i || line_start_i || frame_end_i)) begin
          accept  = 1'b1;
          state_d = S_SYNC;
          lane_d  = {4{SYNC_BYTE}};
          valid_d = 1'b1;
          crc_d   = 16'hFFFF;
        end
      end
      S_SYNC: begin
        state_d = S_HEADER;
        lane_d  = header;
        valid_d = 1'b1;
        ready_d = long_q && (wc_q[15:2] != 14'd0);
        cnt_d   = wc_q[15:2];
      end
      S_HEADER, S_PAYLOAD: begin
        if (!long_q) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else if (data_ready_o) begin
          state_d = S_PAYLOAD;
          lane_d  = word_in;
          valid_d = 1'b1;
          ready_d = (cnt_q != 14'd1);
        end else begin
          state_d = S_FOOTER;
          lane_d  = {16'h0000, crc_q};
          valid_d = 1'b1;
        end
      end
      S_FOOTER: begin
        state_d = S_GAP;
        gap_d   = GAP_LOAD;
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and all outputs; cleared asynchronously so a packet is truncated on reset.
  always_ff @(posedge clk_i or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= S_IDLE;
      cmd_ready_o  <= 1'b0;
      lane_data_o  <= 32'h0;
      lane_valid_o <= 1'b0;
      data_ready_o <= 1'b0;
      underrun_o   <= 1'b0;
      frame_num_o  <= FRAME_NUM_INIT;
    end else begin
      state_q      <= state_d;
      cmd_ready_o  <= (state_d == S_IDLE);
      lane_data_o  <= lane_d;
      lane_valid_o <= valid_d;
      data_ready_o <= ready_d;
      if (accept && frame_start_i)            underrun_o <= 1'b0;
      else if (data_ready_o && !data_valid_i) underrun_o <= 1'b1;
      if (state_q == S_SYNC && is_fe_q)
        frame_num_o <= (frame_num_o == 16'hFFFF) ? 16'd1 : frame_num_o + 16'd1;
    end
  end

  // Packet fields and running counters; always reloaded before use, so not reset.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
    gap_q <= gap_d;
    crc_q <= crc_d;
    if (accept) begin
      if (frame_start_i) begin
        dt_q <= DT_FS;  wc_q <= frame_num_o;  long_q <= 1'b0;  is_fe_q <= 1'b0;
      end else if (line_start_i) begin
        dt_q <= DATA_TYPE;  wc_q <= {word_count_i[15:2], 2'b00};  long_q <= 1'b1;  is_fe_q <= 1'b0;
      end else begin
        dt_q <= DT_FE;  wc_q <= frame_num_o;  long_q <= 1'b0;  is_fe_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mipi_csi_tx_packetizer.sv
// Directed bench for mipi_csi_tx_packetizer: per-scenario tasks with inline checks.
module tb_mipi_csi_tx_packetizer;

  logic        clk_i = 1'b0;
  logic        reset_in = 1'b0;
  logic        frame_start_i = 1'b0, line_start_i = 1'b0, frame_end_i = 1'b0;
  logic [15:0] word_count_i = 16'h0;
  logic [31:0] data_i = 32'h0;
  logic        data_valid_i = 1'b0;
  logic        cmd_ready_o, data_ready_o, lane_valid_o, underrun_o;
  logic [31:0] lane_data_o;
  logic [15:0] frame_num_o;
  logic        w_cmd_ready, w_data_ready, w_lane_valid, w_underrun;
  logic [31:0] w_lane_data;
  logic [15:0] w_frame_num;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  mipi_csi_tx_packetizer dut (
    .clk_i(clk_i), .reset_in(reset_in), .frame_start_i(frame_start_i),
    .line_start_i(line_start_i), .frame_end_i(frame_end_i), .word_count_i(word_count_i),
    .cmd_ready_o(cmd_ready_o), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o), .lane_data_o(lane_data_o), .lane_valid_o(lane_valid_o),
    .underrun_o(underrun_o), .frame_num_o(frame_num_o)
  );

  // Same stimulus, frame counter starting at the wrap point.
  mipi_csi_tx_packetizer #(.FRAME_NUM_INIT(16'hFFFF)) dut_wrap (
    .clk_i(clk_i), .reset_in(reset_in), .frame_start_i(frame_start_i),
    .line_start_i(line_start_i), .frame_end_i(frame_end_i), .word_count_i(word_count_i),
    .cmd_ready_o(w_cmd_ready), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_ready_o(w_data_ready), .lane_data_o(w_lane_data), .lane_valid_o(w_lane_valid),
    .underrun_o(w_underrun), .frame_num_o(w_frame_num)
  );

  // ECC syndrome contributed by each header bit D0..D23.
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  function automatic logic [31:0] m_hdr(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  e;
    d = {wc, di};
    e = 6'h00;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ ECC_COL[i];
    return {2'b00, e, wc, di};
  endfunction

  // Bit-serial reflected CRC-16, LSB of lane 0 first.
  function automatic logic [15:0] m_crc(input logic [15:0] crc, input logic [31:0] w);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int j = 0; j < 32; j++) begin
      fb = c[0] ^ w[j];
      c  = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  logic [31:0] cap_data  [32];
  logic        cap_valid [32];
  logic        cap_ready [32];
  logic        cap_cmd   [32];
  logic        cap_und   [32];
  logic [15:0] cap_fn    [32];
  logic [31:0] feed_word [$];
  logic        feed_vld  [$];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic record(input int i);
    cap_data[i]  = lane_data_o;
    cap_valid[i] = lane_valid_o;
    cap_ready[i] = data_ready_o;
    cap_cmd[i]   = cmd_ready_o;
    cap_und[i]   = underrun_o;
    cap_fn[i]    = frame_num_o;
  endtask

  // Present the next queued word while data_ready_o is high.
  task automatic feed_next();
    if (data_ready_o && feed_word.size() > 0) begin
      data_i       = feed_word.pop_front();
      data_valid_i = feed_vld.pop_front();
    end else begin
      data_i       = 32'h0;
      data_valid_i = 1'b0;
    end
  endtask

  function automatic int count_valid(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap_valid[i]) n++;
    return n;
  endfunction

  function automatic int count_ready(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap_ready[i]) n++;
    return n;
  endfunction

  // kind: bit0 FS, bit1 LS, bit2 FE. cap[0] is the cycle right after acceptance.
  task automatic issue(input logic [2:0] kind, input logic [15:0] wc, input int ncap, input bit hold_fe);
    int  waited = 0;
    logic rdy;
    while (!cmd_ready_o && waited < 64) begin step(); waited++; end
    tests++;
    if (!cmd_ready_o) begin
      fails++;
      $display("FAIL cmd_ready_wait: got %b after %0d cycles, want 1", cmd_ready_o, waited);
    end
    frame_start_i = kind[0];
    line_start_i  = kind[1];
    frame_end_i   = kind[2];
    word_count_i  = wc;
    step();
    frame_start_i = 1'b0;
    line_start_i  = 1'b0;
    frame_end_i   = hold_fe & kind[2];
    for (int i = 0; i < ncap; i++) begin
      record(i);
      rdy = cmd_ready_o;
      feed_next();
      step();
      if (rdy) frame_end_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    tests++; if (lane_data_o !== 32'h0) begin fails++; $display("FAIL rst_lane_data: got %h, want 00000000", lane_data_o); end
    tests++; if (lane_valid_o !== 1'b0) begin fails++; $display("FAIL rst_lane_valid: got %b, want 0", lane_valid_o); end
    tests++; if (data_ready_o !== 1'b0) begin fails++; $display("FAIL rst_data_ready: got %b, want 0", data_ready_o); end
    tests++; if (cmd_ready_o !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready: got %b, want 0", cmd_ready_o); end
    tests++; if (underrun_o !== 1'b0) begin fails++; $display("FAIL rst_underrun: got %b, want 0", underrun_o); end
    tests++; if (frame_num_o !== 16'd1) begin fails++; $display("FAIL rst_frame_num: got %h, want 0001", frame_num_o); end
    reset_in = 1'b1;
    step();
    tests++; if (cmd_ready_o !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready_after: got %b, want 1", cmd_ready_o); end
  endtask

  task automatic test_frame_start();
    int bad = 0;
    issue(3'b001, 16'h0, 10, 1'b0);
    tests++; if (cap_data[0] !== 32'hB8B8B8B8) begin fails++; $display("FAIL fs_sync: got %h, want B8B8B8B8", cap_data[0]); end
    tests++; if (cap_data[1] !== 32'h1A000100) begin fails++; $display("FAIL fs_header: got %h, want 1A000100", cap_data[1]); end
    tests++; if (count_valid(0, 9) != 2 || cap_valid[1] !== 1'b1) begin fails++; $display("FAIL fs_valid_len: got %0d, want 2", count_valid(0, 9)); end
    for (int i = 2; i <= 5; i++) if (cap_valid[i] !== 1'b0 || cap_data[i] !== 32'h0 || cap_cmd[i] !== 1'b0) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL fs_gap: got %0d bad gap cycles, want 0", bad); end
    tests++; if (cap_cmd[6] !== 1'b1) begin fails++; $display("FAIL fs_idle_ready: got %b, want 1", cap_cmd[6]); end
    tests++; if (cap_fn[9] !== 16'd1) begin fails++; $display("FAIL fs_frame_num: got %h, want 0001", cap_fn[9]); end
  endtask

  task automatic test_long_packet();
    logic [15:0] crc;
    feed_word = '{32'h34333231, 32'h38373635};
    feed_vld  = '{1'b1, 1'b1};
    issue(3'b010, 16'd8, 12, 1'b0);
    crc = m_crc(m_crc(16'hFFFF, 32'h34333231), 32'h38373635);
    tests++; if (cap_data[1] !== m_hdr(8'h2B, 16'd8)) begin fails++; $display("FAIL ls_header: got %h, want %h", cap_data[1], m_hdr(8'h2B, 16'd8)); end
    tests++; if (cap_data[2] !== 32'h34333231 || cap_data[3] !== 32'h38373635) begin fails++; $display("FAIL ls_payload: got %h %h, want 34333231 38373635", cap_data[2], cap_data[3]); end
    tests++; if (cap_data[4] !== {16'h0, crc}) begin fails++; $display("FAIL ls_footer: got %h, want %h", cap_data[4], {16'h0, crc}); end
    tests++; if (count_valid(0, 11) != 5 || cap_valid[4] !== 1'b1) begin fails++; $display("FAIL ls_valid_len: got %0d, want 5", count_valid(0, 11)); end
    tests++; if (count_ready(0, 11) != 2 || cap_ready[1] !== 1'b1 || cap_ready[2] !== 1'b1) begin fails++; $display("FAIL ls_ready: got %0d cycles, want 2 at header", count_ready(0, 11)); end
    tests++; if (cap_cmd[9] !== 1'b1 || cap_cmd[8] !== 1'b0) begin fails++; $display("FAIL ls_idle: got %b%b, want 01", cap_cmd[8], cap_cmd[9]); end
  endtask

  task automatic test_word_count_edges();
    logic [15:0] crc;
    issue(3'b010, 16'd0, 8, 1'b0);
    tests++; if (cap_data[1] !== m_hdr(8'h2B, 16'd0)) begin fails++; $display("FAIL wc0_header: got %h, want %h", cap_data[1], m_hdr(8'h2B, 16'd0)); end
    tests++; if (cap_data[2] !== 32'h0000FFFF) begin fails++; $display("FAIL wc0_footer: got %h, want 0000FFFF", cap_data[2]); end
    tests++; if (count_ready(0, 7) != 0 || count_valid(0, 7) != 3) begin fails++; $display("FAIL wc0_lengths: got ready %0d valid %0d, want 0 3", count_ready(0, 7), count_valid(0, 7)); end
    feed_word = '{32'hA5A5A5A5};
    feed_vld  = '{1'b1};
    issue(3'b010, 16'd7, 10, 1'b0);
    crc = m_crc(16'hFFFF, 32'hA5A5A5A5);
    tests++; if (cap_data[1] !== m_hdr(8'h2B, 16'd4)) begin fails++; $display("FAIL wc7_header: got %h, want %h", cap_data[1], m_hdr(8'h2B, 16'd4)); end
    tests++; if (cap_data[2] !== 32'hA5A5A5A5 || cap_data[3] !== {16'h0, crc}) begin fails++; $display("FAIL wc7_body: got %h %h, want A5A5A5A5 %h", cap_data[2], cap_data[3], {16'h0, crc}); end
    tests++; if (count_ready(0, 9) != 1 || count_valid(0, 9) != 4) begin fails++; $display("FAIL wc7_lengths: got ready %0d valid %0d, want 1 4", count_ready(0, 9), count_valid(0, 9)); end
  endtask

  task automatic test_fs_fe_priority();
    issue(3'b101, 16'h0, 20, 1'b1);
    tests++; if (cap_data[1] !== 32'h1A000100) begin fails++; $display("FAIL prio_fs_header: got %h, want 1A000100", cap_data[1]); end
    tests++; if (cap_data[7] !== 32'hB8B8B8B8 || cap_data[8] !== 32'h1D000101) begin fails++; $display("FAIL prio_fe_packet: got %h %h, want B8B8B8B8 1D000101", cap_data[7], cap_data[8]); end
    tests++; if (count_valid(0, 19) != 4) begin fails++; $display("FAIL prio_valid_count: got %0d, want 4", count_valid(0, 19)); end
    tests++; if (cap_fn[7] !== 16'd1 || cap_fn[8] !== 16'd2) begin fails++; $display("FAIL prio_frame_inc: got %h->%h, want 0001->0002", cap_fn[7], cap_fn[8]); end
    tests++; if (w_frame_num !== 16'd1) begin fails++; $display("FAIL frame_wrap: got %h, want 0001", w_frame_num); end
  endtask

  task automatic test_underrun();
    logic [15:0] crc;
    feed_word = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
    feed_vld  = '{1'b1, 1'b0, 1'b1, 1'b1};
    issue(3'b010, 16'd16, 14, 1'b0);
    crc = m_crc(m_crc(m_crc(m_crc(16'hFFFF, 32'h11223344), 32'h0), 32'h99AABBCC), 32'hDDEEFF00);
    tests++; if (cap_data[3] !== 32'h0 || cap_data[4] !== 32'h99AABBCC) begin fails++; $display("FAIL ur_payload: got %h %h, want 00000000 99AABBCC", cap_data[3], cap_data[4]); end
    tests++; if (cap_data[6] !== {16'h0, crc}) begin fails++; $display("FAIL ur_footer: got %h, want %h", cap_data[6], {16'h0, crc}); end
    tests++; if (cap_und[2] !== 1'b0 || cap_und[3] !== 1'b1) begin fails++; $display("FAIL ur_set: got %b%b, want 01", cap_und[2], cap_und[3]); end
    issue(3'b100, 16'h0, 10, 1'b0);
    tests++; if (cap_data[1] !== m_hdr(8'h01, 16'd2)) begin fails++; $display("FAIL ur_fe_header: got %h, want %h", cap_data[1], m_hdr(8'h01, 16'd2)); end
    tests++; if (cap_und[9] !== 1'b1 || cap_fn[9] !== 16'd3) begin fails++; $display("FAIL ur_hold_fe: got und %b fn %h, want 1 0003", cap_und[9], cap_fn[9]); end
    issue(3'b001, 16'h0, 8, 1'b0);
    tests++; if (cap_und[0] !== 1'b0) begin fails++; $display("FAIL ur_clear_fs: got %b, want 0", cap_und[0]); end
    tests++; if (cap_data[1] !== m_hdr(8'h00, 16'd3)) begin fails++; $display("FAIL ur_fs_header: got %h, want %h", cap_data[1], m_hdr(8'h00, 16'd3)); end
  endtask

  task automatic test_back_to_back();
    logic rdy;
    int   bad = 0;
    int   waited = 0;
    feed_word = '{32'hCAFEF00D, 32'h0BADBEEF};
    feed_vld  = '{1'b1, 1'b1};
    while (!cmd_ready_o && waited < 64) begin step(); waited++; end
    line_start_i = 1'b1;
    word_count_i = 16'd4;
    step();
    for (int i = 0; i < 16; i++) begin
      record(i);
      rdy = cmd_ready_o;
      feed_next();
      step();
      if (rdy) line_start_i = 1'b0;
    end
    line_start_i = 1'b0;
    for (int i = 4; i <= 8; i++) if (cap_valid[i] !== 1'b0) bad++;
    tests++; if (cap_valid[3] !== 1'b1 || bad != 0) begin fails++; $display("FAIL b2b_gap: got last %b, %0d high in gap, want 1 0", cap_valid[3], bad); end
    tests++; if (cap_data[9] !== 32'hB8B8B8B8 || cap_valid[9] !== 1'b1) begin fails++; $display("FAIL b2b_sync: got %h %b, want B8B8B8B8 1", cap_data[9], cap_valid[9]); end
    tests++; if (cap_data[12] !== {16'h0, m_crc(16'hFFFF, 32'h0BADBEEF)}) begin fails++; $display("FAIL b2b_footer2: got %h, want %h", cap_data[12], {16'h0, m_crc(16'hFFFF, 32'h0BADBEEF)}); end
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] crc;
    int waited = 0;
    feed_word = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    feed_vld  = '{1'b1, 1'b1, 1'b1, 1'b1};
    while (!cmd_ready_o && waited < 64) begin step(); waited++; end
    line_start_i = 1'b1;
    word_count_i = 16'd16;
    step();
    line_start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin feed_next(); step(); end
    tests++; if (lane_valid_o !== 1'b1 || data_ready_o !== 1'b1) begin fails++; $display("FAIL mid_pre_state: got valid %b ready %b, want 1 1", lane_valid_o, data_ready_o); end
    #2 reset_in = 1'b0;
    #1;
    tests++; if (lane_valid_o !== 1'b0 || data_ready_o !== 1'b0) begin fails++; $display("FAIL mid_async_clear: got valid %b ready %b, want 0 0", lane_valid_o, data_ready_o); end
    tests++; if (lane_data_o !== 32'h0 || frame_num_o !== 16'd1) begin fails++; $display("FAIL mid_async_data: got %h fn %h, want 00000000 0001", lane_data_o, frame_num_o); end
    #1 reset_in = 1'b1;
    feed_word.delete();
    feed_vld.delete();
    data_valid_i = 1'b0;
    step();
    feed_word = '{32'h34333231, 32'h38373635};
    feed_vld  = '{1'b1, 1'b1};
    issue(3'b010, 16'd8, 8, 1'b0);
    crc = m_crc(m_crc(16'hFFFF, 32'h34333231), 32'h38373635);
    tests++; if (cap_data[0] !== 32'hB8B8B8B8 || cap_data[1] !== m_hdr(8'h2B, 16'd8)) begin fails++; $display("FAIL mid_restart_hdr: got %h %h, want B8B8B8B8 %h", cap_data[0], cap_data[1], m_hdr(8'h2B, 16'd8)); end
    tests++; if (cap_data[4] !== {16'h0, crc}) begin fails++; $display("FAIL mid_restart_crc: got %h, want %h", cap_data[4], {16'h0, crc}); end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_long_packet();
    test_word_count_edges();
    test_fs_fe_priority();
    test_underrun();
    test_back_to_back();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
